adc_decimator: RTL and testbench



---
 rtl/adc_decimator.sv | 90 +++++++++
 tb/tb_adc_decimator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/adc_decimator.sv
// adc_decimator
//   Removes the mid-scale offset from offset-binary ADC samples and boxcar-
//   averages blocks of DECIM samples into one signed 16-bit output sample.
//   The output feeds the LMS stage directly.
//
// Ports:
//   clk_in     system clock
//   rst_in     synchronous active-high reset
//   valid_in   adc_in carries a new sample this cycle
//   adc_in     offset-binary ADC sample, IN_W bits
//   sync_in    one-cycle pulse restarting block alignment
//   ready_out  one-cycle strobe, x_out is new
//   x_out      signed decimated sample, held between strobes
//   phase_out  samples accumulated in the current block (0..DECIM-1)
module adc_decimator #(
  parameter int IN_W  = 12,
  parameter int DECIM = 16,
  parameter int OUT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  adc_in,
  input  logic             sync_in,
  output logic             ready_out,
  output logic [OUT_W-1:0] x_out,
  output logic [7:0]       phase_out
);

  localparam int L     = $clog2(DECIM);
  localparam int ACC_W = IN_W + L;
  localparam logic [IN_W:0] MID = (IN_W+1)'(1) << (IN_W-1);

  logic signed [IN_W:0]      s;
  logic signed [ACC_W-1:0]   s_ext;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   sum;
  logic signed [OUT_W-1:0]   scaled;
  logic        [L-1:0]       cnt;
  logic                      last;

  // Unsigned subtract wraps modulo 2^(IN_W+1); reading it back as signed
  // gives the offset-removed sample directly.
  assign s     = $signed({1'b0, adc_in} - MID);
  assign s_ext = s;                      // sign-extends to accumulator width
  assign sum   = acc + s_ext;
  assign last  = (cnt == L'(DECIM-1));

  // Bring the block sum to the output width. A right shift keeps the top
  // bits (floor division); a left shift pads with zeros.
  generate
    if (ACC_W > OUT_W) begin : g_shr
      assign scaled = OUT_W'(sum >>> (ACC_W-OUT_W));
    end else if (ACC_W < OUT_W) begin : g_shl
      assign scaled = {sum, {(OUT_W-ACC_W){1'b0}}};
    end else begin : g_pass
      assign scaled = sum;
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc       <= '0;
      cnt       <= '0;
      x_out     <= '0;
      ready_out <= 1'b0;
    end else begin
      ready_out <= 1'b0;
      if (sync_in && valid_in) begin
        // Sync wins even over a block-completing sample: no strobe.
        acc <= s_ext;
        cnt <= L'(1);
      end else if (sync_in) begin
        acc <= '0;
        cnt <= '0;
      end else if (valid_in && last) begin
        x_out     <= scaled;
        ready_out <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
      end else if (valid_in) begin
        acc <= sum;
        cnt <= cnt + L'(1);
      end
    end
  end

  assign phase_out = 8'(cnt);

endmodule

// File: tb/tb_adc_decimator.sv
// tb_adc_decimator
//   Directed test of adc_decimator: default build (IN_W=12, DECIM=16) plus a
//   DECIM=4 instance exercising the left-shift scaling path.
module tb_adc_decimator;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, sync;
  logic [11:0] adc;
  logic        rdy;
  logic [15:0] x;
  logic [7:0]  ph;

  logic        valid4, sync4;
  logic [11:0] adc4;
  logic        rdy4;
  logic [15:0] x4;
  logic [7:0]  ph4;

  adc_decimator dut (
    .clk_in(clk), .rst_in(rst), .valid_in(valid), .adc_in(adc), .sync_in(sync),
    .ready_out(rdy), .x_out(x), .phase_out(ph)
  );

  adc_decimator #(.IN_W(12), .DECIM(4), .OUT_W(16)) dut4 (
    .clk_in(clk), .rst_in(rst), .valid_in(valid4), .adc_in(adc4), .sync_in(sync4),
    .ready_out(rdy4), .x_out(x4), .phase_out(ph4)
  );

  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, n_stb = 0, n_wide = 0, s0 = 0;
  logic rdy_d = 1'b0;
  int   stb_cyc[$];

  // Strobe monitor: the value seen at the posedge is the one held during
  // the preceding cycle.
  always @(posedge clk) begin
    cyc++;
    if (rdy === 1'b1) begin
      n_stb++;
      stb_cyc.push_back(cyc);
      if (rdy_d === 1'b1) n_wide++;
    end
    rdy_d = rdy;
  end

  task automatic chk(input string tag, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // One sample; returns at the negedge right after the accepting edge.
  task automatic send(input logic [11:0] v, input logic s);
    @(negedge clk); valid = 1'b1; adc = v; sync = s;
    @(negedge clk); valid = 1'b0; sync = 1'b0;
  endtask

  task automatic blk(input logic [11:0] v, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap-1) @(negedge clk);
      send(v, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; sync = 1'b0; adc = '0;
    valid4 = 1'b0; sync4 = 1'b0; adc4 = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy, 0);
    chk("rst_x", $signed(x), 0);
    chk("rst_ph", ph, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // mid-scale input averages to zero
    blk(12'd2048, 16, 8);
    chk("t1_rdy", rdy, 1);
    chk("t1_x", $signed(x), 0);
    chk("t1_ph", ph, 0);
    @(negedge clk);
    chk("t1_width", rdy, 0);
    chk("t1_nstb", n_stb, 1);

    // full-scale positive then negative
    repeat (6) @(negedge clk);
    s0 = n_stb;
    blk(12'd4095, 5, 8);
    chk("t2_ph5", ph, 5);
    repeat (7) @(negedge clk);
    blk(12'd4095, 11, 8);
    chk("t2_rdy_hi", rdy, 1);
    chk("t2_x_hi", $signed(x), 32752);
    repeat (7) @(negedge clk);
    blk(12'd0, 16, 8);
    chk("t2_rdy_lo", rdy, 1);
    chk("t2_x_lo", $signed(x), -32768);
    @(negedge clk);
    chk("t2_nstb", n_stb - s0, 2);

    // back-to-back samples
    repeat (4) @(negedge clk);
    stb_cyc.delete();
    s0 = n_stb;
    @(negedge clk); valid = 1'b1; adc = 12'd2049;
    repeat (64) @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_nstb", n_stb - s0, 4);
    for (int i = 1; i < stb_cyc.size(); i++)
      chk($sformatf("t3_gap%0d", i), stb_cyc[i] - stb_cyc[i-1], 16);
    chk("t3_x", $signed(x), 16);
    chk("t3_ph", ph, 0);

    // sync with a sample mid-block discards the partial block
    repeat (4) @(negedge clk);
    blk(12'd4095, 7, 8);
    repeat (7) @(negedge clk);
    s0 = n_stb;
    send(12'd2148, 1'b1);
    chk("t4_sync_rdy", rdy, 0);
    chk("t4_sync_ph", ph, 1);
    repeat (7) @(negedge clk);
    blk(12'd2048, 15, 8);
    chk("t4_rdy", rdy, 1);
    chk("t4_x", $signed(x), 100);
    @(negedge clk);
    chk("t4_nstb", n_stb - s0, 1);

    // sync on the block-completing sample suppresses the strobe
    repeat (4) @(negedge clk);
    blk(12'd2048, 15, 8);
    repeat (7) @(negedge clk);
    s0 = n_stb;
    send(12'd2053, 1'b1);
    chk("t5_sync_rdy", rdy, 0);
    chk("t5_sync_ph", ph, 1);
    chk("t5_x_held", $signed(x), 100);
    repeat (7) @(negedge clk);
    blk(12'd2048, 15, 8);
    chk("t5_x", $signed(x), 5);
    @(negedge clk);
    chk("t5_nstb", n_stb - s0, 1);

    // reset mid-block
    repeat (4) @(negedge clk);
    blk(12'd3000, 9, 8);
    chk("t6_ph9", ph, 9);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t6_rst_x", $signed(x), 0);
    chk("t6_rst_ph", ph, 0);
    chk("t6_rst_rdy", rdy, 0);
    blk(12'd2052, 16, 8);
    chk("t6_x", $signed(x), 64);

    // DECIM=4 instance: 14-bit sum shifted left by 2
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); valid4 = 1'b1; adc4 = 12'd2049;
      @(negedge clk); valid4 = 1'b0;
      if (i == 2) begin
        chk("t7_ph3", ph4, 3);
        chk("t7_rdy_early", rdy4, 0);
      end
      if (i < 3) repeat (6) @(negedge clk);
    end
    chk("t7_rdy", rdy4, 1);
    chk("t7_x", $signed(x4), 16);
    @(negedge clk);
    chk("t7_width", rdy4, 0);

    chk("wide_pulses", n_wide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
